// File: rtl/ysyx_040750_axi_wr_arbiter_pkg.sv
// Shared definitions for the AXI4 write-path arbiter.
// - wr_state_e : one-hot FSM encoding (IDLE, AWR, WR, BR)
// - CH0 / CH1  : channel identifiers (CH0 = dcache write-back, CH1 = uncached/MMIO store)
// - BURST_* / RESP_* : AXI4 burst type and write-response codes
package ysyx_040750_axi_wr_arbiter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_AWR  = 4'b0010,
    ST_WR   = 4'b0100,
    ST_BR   = 4'b1000
  } wr_state_e;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_040750_axi_wr_arbiter.sv
// ysyx_040750_axi_wr_arbiter
// Shares one AXI4 write path (AW/W/B) between two masters: ch0 = dcache
// write-back, ch1 = uncached/MMIO store. Exactly one transaction is in
// flight: AW, then the whole W burst, then B, all owned by one channel.
// Simultaneous requests are resolved round-robin.
//
// Parameters: DW write data width (strobe DW/8), AW address width.
// Ports:
//   I_clk, I_rst                      clock, synchronous active-high reset
//   I_chN_aw*/O_chN_awready           per-channel write address request
//   I_chN_w*/O_chN_wready             per-channel write beats
//   O_chN_bvalid/_bresp, I_chN_bready per-channel write response
//   O_axi_aw*/I_axi_awready           bus address channel
//   O_axi_w*/I_axi_wready             bus data channel
//   I_axi_bvalid/_bresp, O_axi_bready bus response channel
//
// Build option: define YSYX_040750_WR_FIXED_PRIO_EN to make ch0 always win
// simultaneous requests (prio is then held at ch0).
module ysyx_040750_axi_wr_arbiter
  import ysyx_040750_axi_wr_arbiter_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 32
) (
  input  logic            I_clk,
  input  logic            I_rst,
  // channel 0
  input  logic            I_ch0_awvalid,
  input  logic [AW-1:0]   I_ch0_awaddr,
  input  logic [7:0]      I_ch0_awlen,
  input  logic [2:0]      I_ch0_awsize,
  input  logic [1:0]      I_ch0_awburst,
  output logic            O_ch0_awready,
  input  logic            I_ch0_wvalid,
  input  logic [DW-1:0]   I_ch0_wdata,
  input  logic [DW/8-1:0] I_ch0_wstrb,
  input  logic            I_ch0_wlast,
  output logic            O_ch0_wready,
  output logic            O_ch0_bvalid,
  output logic [1:0]      O_ch0_bresp,
  input  logic            I_ch0_bready,
  // channel 1
  input  logic            I_ch1_awvalid,
  input  logic [AW-1:0]   I_ch1_awaddr,
  input  logic [7:0]      I_ch1_awlen,
  input  logic [2:0]      I_ch1_awsize,
  input  logic [1:0]      I_ch1_awburst,
  output logic            O_ch1_awready,
  input  logic            I_ch1_wvalid,
  input  logic [DW-1:0]   I_ch1_wdata,
  input  logic [DW/8-1:0] I_ch1_wstrb,
  input  logic            I_ch1_wlast,
  output logic            O_ch1_wready,
  output logic            O_ch1_bvalid,
  output logic [1:0]      O_ch1_bresp,
  input  logic            I_ch1_bready,
  // bus side
  output logic            O_axi_awvalid,
  output logic [AW-1:0]   O_axi_awaddr,
  output logic [7:0]      O_axi_awlen,
  output logic [2:0]      O_axi_awsize,
  output logic [1:0]      O_axi_awburst,
  input  logic            I_axi_awready,
  output logic            O_axi_wvalid,
  output logic [DW-1:0]   O_axi_wdata,
  output logic [DW/8-1:0] O_axi_wstrb,
  output logic            O_axi_wlast,
  input  logic            I_axi_wready,
  input  logic            I_axi_bvalid,
  input  logic [1:0]      I_axi_bresp,
  output logic            O_axi_bready
);

  wr_state_e  state;
  logic       owner;
  logic       prio;
  logic [7:0] cnt;
  logic [7:0] len_q;

  logic            grant;
  logic            sel;
  logic            req_any;
  logic            aw_phase;
  logic            w_phase;
  logic            b_phase;
  logic            last_beat;
  logic            aw_hs;
  logic            w_hs;
  logic            b_hs;
  logic            sel_awvalid;
  logic [AW-1:0]   sel_awaddr;
  logic [7:0]      sel_awlen;
  logic [2:0]      sel_awsize;
  logic [1:0]      sel_awburst;
  logic            sel_wvalid;
  logic [DW-1:0]   sel_wdata;
  logic [DW/8-1:0] sel_wstrb;
  logic            sel_bready;

  // Burst length comes from awlen only, so the masters' wlast is never consulted.
  logic unused_wlast;
  assign unused_wlast = I_ch0_wlast ^ I_ch1_wlast;

  // Grant decision, only meaningful in IDLE. The no-request case falls back
  // to prio so that prio stays referenced in the fixed-priority build.
  always_comb begin
    grant = CH0;
`ifdef YSYX_040750_WR_FIXED_PRIO_EN
    grant = I_ch0_awvalid ? CH0 : (I_ch1_awvalid ? CH1 : prio);
`else
    if (I_ch0_awvalid && I_ch1_awvalid) grant = prio;
    else if (I_ch1_awvalid)             grant = CH1;
    else                                grant = CH0;
`endif
  end

  // In IDLE the fresh grant steers the muxes so AW goes out in the same cycle;
  // afterwards the registered owner holds the path until the B handshake.
  assign req_any   = I_ch0_awvalid | I_ch1_awvalid;
  assign sel       = (state == ST_IDLE) ? grant : owner;
  assign aw_phase  = ((state == ST_IDLE) && req_any) || (state == ST_AWR);
  assign w_phase   = (state == ST_WR);
  assign b_phase   = (state == ST_BR);
  assign last_beat = (cnt == len_q);

  // Pick the selected channel's request fields.
  always_comb begin
    sel_awvalid = I_ch0_awvalid;
    sel_awaddr  = I_ch0_awaddr;
    sel_awlen   = I_ch0_awlen;
    sel_awsize  = I_ch0_awsize;
    sel_awburst = I_ch0_awburst;
    sel_wvalid  = I_ch0_wvalid;
    sel_wdata   = I_ch0_wdata;
    sel_wstrb   = I_ch0_wstrb;
    sel_bready  = I_ch0_bready;
    if (sel == CH1) begin
      sel_awvalid = I_ch1_awvalid;
      sel_awaddr  = I_ch1_awaddr;
      sel_awlen   = I_ch1_awlen;
      sel_awsize  = I_ch1_awsize;
      sel_awburst = I_ch1_awburst;
      sel_wvalid  = I_ch1_wvalid;
      sel_wdata   = I_ch1_wdata;
      sel_wstrb   = I_ch1_wstrb;
      sel_bready  = I_ch1_bready;
    end
  end

  // Bus-side outputs are zero outside their phase; channel-side handshakes
  // only ever reach the selected channel.
  always_comb begin
    O_axi_awvalid = aw_phase & sel_awvalid;
    O_axi_awaddr  = aw_phase ? sel_awaddr  : '0;
    O_axi_awlen   = aw_phase ? sel_awlen   : 8'd0;
    O_axi_awsize  = aw_phase ? sel_awsize  : 3'd0;
    O_axi_awburst = aw_phase ? sel_awburst : BURST_FIXED;
    O_axi_wvalid  = w_phase & sel_wvalid;
    O_axi_wdata   = w_phase ? sel_wdata : '0;
    O_axi_wstrb   = w_phase ? sel_wstrb : '0;
    O_axi_wlast   = w_phase & last_beat;
    O_axi_bready  = b_phase & sel_bready;

    O_ch0_awready = aw_phase & (sel == CH0) & I_axi_awready;
    O_ch1_awready = aw_phase & (sel == CH1) & I_axi_awready;
    O_ch0_wready  = w_phase  & (sel == CH0) & I_axi_wready;
    O_ch1_wready  = w_phase  & (sel == CH1) & I_axi_wready;
    O_ch0_bvalid  = b_phase  & (sel == CH0) & I_axi_bvalid;
    O_ch1_bvalid  = b_phase  & (sel == CH1) & I_axi_bvalid;
    O_ch0_bresp   = (b_phase && (sel == CH0)) ? I_axi_bresp : RESP_OKAY;
    O_ch1_bresp   = (b_phase && (sel == CH1)) ? I_axi_bresp : RESP_OKAY;
  end

  assign aw_hs = O_axi_awvalid & I_axi_awready;
  assign w_hs  = O_axi_wvalid & I_axi_wready;
  assign b_hs  = I_axi_bvalid & O_axi_bready;

  // Transaction FSM. cnt is 8 bits; with len_q = 255 the final beat is at
  // cnt = 255, so the wrap back to 0 only happens after the burst is done.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state <= ST_IDLE;
      owner <= CH0;
      prio  <= CH0;
      cnt   <= 8'd0;
      len_q <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            owner <= grant;
            if (aw_hs) begin
              len_q <= sel_awlen;
              cnt   <= 8'd0;
              state <= ST_WR;
            end else begin
              state <= ST_AWR;
            end
          end
        end
        ST_AWR: begin
          if (aw_hs) begin
            len_q <= sel_awlen;
            cnt   <= 8'd0;
            state <= ST_WR;
          end
        end
        ST_WR: begin
          if (w_hs) begin
            cnt <= cnt + 8'd1;
            if (last_beat) state <= ST_BR;
          end
        end
        ST_BR: begin
          if (b_hs) begin
            state <= ST_IDLE;
`ifdef YSYX_040750_WR_FIXED_PRIO_EN
            prio  <= CH0;
`else
            prio  <= ~owner;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_040750_axi_wr_arbiter.sv
// Testbench for ysyx_040750_axi_wr_arbiter: table of arbitration scenarios
// run against bench-side masters and a bus slave, with a scoreboard of
// expected bus transactions, plus a hand-written reset-mid-burst sequence.
module tb_ysyx_040750_axi_wr_arbiter;
  import ysyx_040750_axi_wr_arbiter_pkg::*;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int ROW_LIMIT = 3000;

  logic I_clk = 1'b0;
  logic I_rst;
  logic I_ch0_awvalid, I_ch1_awvalid;
  logic [AW-1:0] I_ch0_awaddr, I_ch1_awaddr;
  logic [7:0] I_ch0_awlen, I_ch1_awlen;
  logic [2:0] I_ch0_awsize, I_ch1_awsize;
  logic [1:0] I_ch0_awburst, I_ch1_awburst;
  logic O_ch0_awready, O_ch1_awready;
  logic I_ch0_wvalid, I_ch1_wvalid;
  logic [DW-1:0] I_ch0_wdata, I_ch1_wdata;
  logic [DW/8-1:0] I_ch0_wstrb, I_ch1_wstrb;
  logic I_ch0_wlast, I_ch1_wlast;
  logic O_ch0_wready, O_ch1_wready;
  logic O_ch0_bvalid, O_ch1_bvalid;
  logic [1:0] O_ch0_bresp, O_ch1_bresp;
  logic I_ch0_bready, I_ch1_bready;
  logic O_axi_awvalid;
  logic [AW-1:0] O_axi_awaddr;
  logic [7:0] O_axi_awlen;
  logic [2:0] O_axi_awsize;
  logic [1:0] O_axi_awburst;
  logic I_axi_awready;
  logic O_axi_wvalid;
  logic [DW-1:0] O_axi_wdata;
  logic [DW/8-1:0] O_axi_wstrb;
  logic O_axi_wlast;
  logic I_axi_wready;
  logic I_axi_bvalid;
  logic [1:0] I_axi_bresp;
  logic O_axi_bready;

  ysyx_040750_axi_wr_arbiter #(.DW(DW), .AW(AW)) dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_ch0_awvalid(I_ch0_awvalid), .I_ch0_awaddr(I_ch0_awaddr), .I_ch0_awlen(I_ch0_awlen),
    .I_ch0_awsize(I_ch0_awsize), .I_ch0_awburst(I_ch0_awburst), .O_ch0_awready(O_ch0_awready),
    .I_ch0_wvalid(I_ch0_wvalid), .I_ch0_wdata(I_ch0_wdata), .I_ch0_wstrb(I_ch0_wstrb),
    .I_ch0_wlast(I_ch0_wlast), .O_ch0_wready(O_ch0_wready),
    .O_ch0_bvalid(O_ch0_bvalid), .O_ch0_bresp(O_ch0_bresp), .I_ch0_bready(I_ch0_bready),
    .I_ch1_awvalid(I_ch1_awvalid), .I_ch1_awaddr(I_ch1_awaddr), .I_ch1_awlen(I_ch1_awlen),
    .I_ch1_awsize(I_ch1_awsize), .I_ch1_awburst(I_ch1_awburst), .O_ch1_awready(O_ch1_awready),
    .I_ch1_wvalid(I_ch1_wvalid), .I_ch1_wdata(I_ch1_wdata), .I_ch1_wstrb(I_ch1_wstrb),
    .I_ch1_wlast(I_ch1_wlast), .O_ch1_wready(O_ch1_wready),
    .O_ch1_bvalid(O_ch1_bvalid), .O_ch1_bresp(O_ch1_bresp), .I_ch1_bready(I_ch1_bready),
    .O_axi_awvalid(O_axi_awvalid), .O_axi_awaddr(O_axi_awaddr), .O_axi_awlen(O_axi_awlen),
    .O_axi_awsize(O_axi_awsize), .O_axi_awburst(O_axi_awburst), .I_axi_awready(I_axi_awready),
    .O_axi_wvalid(O_axi_wvalid), .O_axi_wdata(O_axi_wdata), .O_axi_wstrb(O_axi_wstrb),
    .O_axi_wlast(O_axi_wlast), .I_axi_wready(I_axi_wready),
    .I_axi_bvalid(I_axi_bvalid), .I_axi_bresp(I_axi_bresp), .O_axi_bready(O_axi_bready)
  );

  always #5 I_clk = ~I_clk;

  int checks = 0;
  int errors = 0;

  // One arbitration scenario; expOrder bit i is the channel of the i-th bus transaction.
  typedef struct {
    int         n0;
    int         n1;
    logic [7:0] len0;
    logic [7:0] len1;
    int         ch1Delay;
    bit         rnd;
    int         awHold;
    logic [1:0] bresp;
    int         bready1Delay;
    int         expN;
    logic [2:0] expOrder;
  } vec_t;

  typedef struct {
    logic       ch;
    logic [7:0] job;
    logic [7:0] len;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  bit   busBusy, awDone, wDone, bPend;
  int   curBeat, awHoldLeft;

  int         phase[2];
  int         jobsLeft[2];
  int         jobIdx[2];
  int         beatIdx[2];
  int         startDelay[2];
  int         bDelay[2];
  logic [7:0] mlen[2];

`ifdef YSYX_040750_WR_FIXED_PRIO_EN
  localparam logic [2:0] ORD_ROW0 = 3'b100;
  localparam logic [2:0] ORD_ROW2 = 3'b010;
`else
  localparam logic [2:0] ORD_ROW0 = 3'b010;
  localparam logic [2:0] ORD_ROW2 = 3'b001;
`endif

  function automatic logic [AW-1:0] mkAddr(input logic ch, input int job);
    return 32'h8000_0000 + (ch ? 32'h0001_0000 : 32'h0) + 32'(job) * 32'h100;
  endfunction

  function automatic logic [DW-1:0] mkData(input logic ch, input int job, input int beat);
    return {16'hC0DE, 7'd0, ch, 8'(job), 32'(beat)};
  endfunction

  function automatic logic [DW/8-1:0] mkStrb(input logic ch, input int beat);
    return 8'(beat) ^ {7'd0, ch} ^ 8'h5A;
  endfunction

  function automatic logic [8:0] validReadyVec();
    return {O_ch0_awready, O_ch1_awready, O_ch0_wready, O_ch1_wready,
            O_ch0_bvalid, O_ch1_bvalid, O_axi_awvalid, O_axi_wvalid, O_axi_bready};
  endfunction

  function automatic vec_t mkVec(input int n0, input int n1, input int len0, input int len1,
                                 input int ch1Delay, input bit rnd, input int awHold,
                                 input logic [1:0] bresp, input int bdly, input int expN,
                                 input logic [2:0] order);
    vec_t v;
    v.n0 = n0; v.n1 = n1; v.len0 = 8'(len0); v.len1 = 8'(len1);
    v.ch1Delay = ch1Delay; v.rnd = rnd; v.awHold = awHold; v.bresp = bresp;
    v.bready1Delay = bdly; v.expN = expN; v.expOrder = order;
    return v;
  endfunction

  // Compare and count; any mismatch prints a single FAIL line.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  // Everything quiet; the bus slave is ready and offers a stray bvalid to prove gating.
  task automatic applyIdle(input logic straybvalid);
    I_ch0_awvalid = 0; I_ch1_awvalid = 0;
    I_ch0_awaddr = '0; I_ch1_awaddr = '0; I_ch0_awlen = 0; I_ch1_awlen = 0;
    I_ch0_awsize = 0; I_ch1_awsize = 0; I_ch0_awburst = 0; I_ch1_awburst = 0;
    I_ch0_wvalid = 0; I_ch1_wvalid = 0; I_ch0_wdata = '0; I_ch1_wdata = '0;
    I_ch0_wstrb = '0; I_ch1_wstrb = '0; I_ch0_wlast = 0; I_ch1_wlast = 0;
    I_ch0_bready = 1; I_ch1_bready = 1;
    I_axi_awready = 1; I_axi_wready = 1; I_axi_bvalid = straybvalid; I_axi_bresp = RESP_DECERR;
  endtask

  // Drive masters and bus slave from the bench state for one cycle.
  task automatic applyStimulus(input vec_t v);
    I_ch0_awvalid = (phase[0] == 1);
    I_ch0_awaddr  = mkAddr(1'b0, jobIdx[0]);
    I_ch0_awlen   = mlen[0];
    I_ch0_awsize  = 3'd3;
    I_ch0_awburst = BURST_INCR;
    I_ch0_wvalid  = (phase[0] == 2) && (v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
    I_ch0_wdata   = mkData(1'b0, jobIdx[0], beatIdx[0]);
    I_ch0_wstrb   = mkStrb(1'b0, beatIdx[0]);
    I_ch0_wlast   = 1'($urandom_range(0, 1));
    I_ch0_bready  = (phase[0] == 3);
    I_ch1_awvalid = (phase[1] == 1);
    I_ch1_awaddr  = mkAddr(1'b1, jobIdx[1]);
    I_ch1_awlen   = mlen[1];
    I_ch1_awsize  = 3'd3;
    I_ch1_awburst = BURST_INCR;
    I_ch1_wvalid  = (phase[1] == 2) && (v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
    I_ch1_wdata   = mkData(1'b1, jobIdx[1], beatIdx[1]);
    I_ch1_wstrb   = mkStrb(1'b1, beatIdx[1]);
    I_ch1_wlast   = 1'($urandom_range(0, 1));
    I_ch1_bready  = (phase[1] == 3) && (bDelay[1] == 0);
    I_axi_awready = (awHoldLeft > 0) ? 1'b0 : (v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
    I_axi_wready  = v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    I_axi_bvalid  = bPend;
    I_axi_bresp   = v.bresp;
  endtask

  // Scoreboard step: compare the settled outputs and advance bench state on handshakes.
  task automatic checkCycle(input vec_t v);
    logic own_aw, own_w, own_b, oth_aw, oth_w, oth_b, own_wv, own_br;
    logic [1:0] own_resp;
    if (!busBusy && (I_ch0_awvalid || I_ch1_awvalid)) begin
      checkOutput("sb_has_expected", 64'(expQ.size() != 0), 64'd1);
      checkOutput("aw_zero_latency", 64'(O_axi_awvalid), 64'd1);
      if (expQ.size() != 0) begin
        cur = expQ.pop_front();
        busBusy = 1; awDone = 0; wDone = 0; curBeat = 0;
      end
    end
    if (busBusy) begin
      own_aw = cur.ch ? O_ch1_awready : O_ch0_awready;
      oth_aw = cur.ch ? O_ch0_awready : O_ch1_awready;
      own_w  = cur.ch ? O_ch1_wready  : O_ch0_wready;
      oth_w  = cur.ch ? O_ch0_wready  : O_ch1_wready;
      own_b  = cur.ch ? O_ch1_bvalid  : O_ch0_bvalid;
      oth_b  = cur.ch ? O_ch0_bvalid  : O_ch1_bvalid;
      own_resp = cur.ch ? O_ch1_bresp : O_ch0_bresp;
      own_wv = cur.ch ? I_ch1_wvalid : I_ch0_wvalid;
      own_br = cur.ch ? I_ch1_bready : I_ch0_bready;
      checkOutput("nonowner_awready", 64'(oth_aw), 64'd0);
      checkOutput("nonowner_wready", 64'(oth_w), 64'd0);
      checkOutput("nonowner_bvalid", 64'(oth_b), 64'd0);
      if (!awDone) begin
        checkOutput("aw_valid", 64'(O_axi_awvalid), 64'd1);
        checkOutput("aw_addr", 64'(O_axi_awaddr), 64'(mkAddr(cur.ch, int'(cur.job))));
        checkOutput("aw_len", 64'(O_axi_awlen), 64'(cur.len));
        checkOutput("aw_burst", 64'(O_axi_awburst), 64'(BURST_INCR));
        checkOutput("aw_ready_owner", 64'(own_aw), 64'(I_axi_awready));
        checkOutput("w_before_aw", 64'(O_axi_wvalid), 64'd0);
        if (O_axi_awvalid && I_axi_awready) begin
          awDone = 1;
          phase[cur.ch] = 2;
          beatIdx[cur.ch] = 0;
        end
      end else if (!wDone) begin
        checkOutput("w_valid", 64'(O_axi_wvalid), 64'(own_wv));
        checkOutput("w_ready_owner", 64'(own_w), 64'(I_axi_wready));
        checkOutput("aw_after_hs", 64'(O_axi_awvalid), 64'd0);
        if (own_wv) begin
          checkOutput("w_data", O_axi_wdata, mkData(cur.ch, int'(cur.job), curBeat));
          checkOutput("w_strb", 64'(O_axi_wstrb), 64'(mkStrb(cur.ch, curBeat)));
          checkOutput("w_last", 64'(O_axi_wlast), 64'(curBeat == int'(cur.len)));
          if (I_axi_wready) begin
            if (curBeat == int'(cur.len)) begin
              wDone = 1; bPend = 1; phase[cur.ch] = 3;
            end
            curBeat++;
            beatIdx[cur.ch]++;
          end
        end
      end else begin
        checkOutput("w_after_last", 64'(O_axi_wvalid), 64'd0);
        checkOutput("b_valid_owner", 64'(own_b), 64'(bPend));
        checkOutput("b_ready_bus", 64'(O_axi_bready), 64'(own_br));
        if (bPend) checkOutput("b_resp", 64'(own_resp), 64'(v.bresp));
        if (bPend && own_br) begin
          bPend = 0; busBusy = 0;
          jobsLeft[cur.ch]--;
          jobIdx[cur.ch]++;
          phase[cur.ch] = (jobsLeft[cur.ch] > 0) ? 1 : 4;
        end else if (bPend && bDelay[cur.ch] > 0) begin
          bDelay[cur.ch]--;
        end
      end
    end
    if (awHoldLeft > 0) awHoldLeft--;
    for (int c = 0; c < 2; c++)
      if (phase[c] == 0) begin
        startDelay[c]--;
        if (startDelay[c] <= 0) phase[c] = 1;
      end
  endtask

  task automatic runVector(input vec_t v, input int idx);
    int jc[2];
    int cycles;
    exp_t e;
    jc[0] = 0; jc[1] = 0;
    jobsLeft[0] = v.n0; jobsLeft[1] = v.n1;
    jobIdx[0] = 0; jobIdx[1] = 0; beatIdx[0] = 0; beatIdx[1] = 0;
    mlen[0] = v.len0; mlen[1] = v.len1;
    startDelay[0] = 0; startDelay[1] = v.ch1Delay;
    bDelay[0] = 0; bDelay[1] = v.bready1Delay;
    phase[0] = (v.n0 > 0) ? 1 : 4;
    phase[1] = (v.n1 > 0) ? ((v.ch1Delay > 0) ? 0 : 1) : 4;
    awHoldLeft = v.awHold;
    busBusy = 0; bPend = 0;
    for (int i = 0; i < v.expN; i++) begin
      e.ch = v.expOrder[i];
      e.job = 8'(jc[e.ch]);
      e.len = e.ch ? v.len1 : v.len0;
      jc[e.ch]++;
      expQ.push_back(e);
    end
    cycles = 0;
    while (!(phase[0] == 4 && phase[1] == 4 && !busBusy) && cycles < ROW_LIMIT) begin
      applyStimulus(v);
      #3;
      checkCycle(v);
      step();
      cycles++;
    end
    if (cycles >= ROW_LIMIT) begin
      checks++; errors++;
      $display("[TB] FAIL row%0d_timeout: got %0d cycles, want < %0d", idx, cycles, ROW_LIMIT);
    end
    checkOutput($sformatf("row%0d_all_served", idx), 64'(expQ.size()), 64'd0);
    expQ.delete();
    applyIdle(1'b0);
    #3;
    checkOutput($sformatf("row%0d_idle_after", idx), 64'(validReadyVec()), 64'd0);
    step();
  endtask

  vec_t vecs[8];

  initial begin
    // {n0, n1, len0, len1, ch1Delay, rnd, awHold, bresp, bready1Delay, expN, order}
    vecs[0] = mkVec(2, 1, 3, 1, 0, 0, 0, RESP_OKAY, 0, 3, ORD_ROW0);
    vecs[1] = mkVec(1, 0, 3, 0, 0, 0, 0, RESP_OKAY, 0, 1, 3'b000);
    vecs[2] = mkVec(1, 1, 2, 4, 0, 0, 0, RESP_EXOKAY, 0, 2, ORD_ROW2);
    vecs[3] = mkVec(1, 1, 2, 1, 1, 0, 5, RESP_OKAY, 0, 2, 3'b010);
    vecs[4] = mkVec(1, 1, 0, 1, 1, 1, 0, RESP_OKAY, 0, 2, 3'b010);
    vecs[5] = mkVec(0, 1, 0, 2, 0, 0, 0, RESP_SLVERR, 3, 1, 3'b001);
    vecs[6] = mkVec(1, 1, 255, 5, 0, 0, 0, RESP_OKAY, 0, 2, 3'b010);
    vecs[7] = mkVec(1, 0, 0, 0, 0, 0, 0, RESP_OKAY, 0, 1, 3'b000);

    applyIdle(1'b0);
    I_rst = 1;
    repeat (3) step();
    I_rst = 0;
    applyIdle(1'b1);
    #3;
    checkOutput("reset_valid_ready", 64'(validReadyVec()), 64'd0);
    checkOutput("reset_awaddr", 64'(O_axi_awaddr), 64'd0);
    checkOutput("reset_wlast", 64'(O_axi_wlast), 64'd0);
    checkOutput("reset_bresp", 64'({O_ch0_bresp, O_ch1_bresp}), 64'd0);
    step();

    for (int i = 0; i < 8; i++) runVector(vecs[i], i);

    // Reset during a ch1 burst after two beats; prio was left pointing at ch1.
    applyIdle(1'b0);
    I_ch1_awvalid = 1; I_ch1_awaddr = mkAddr(1'b1, 9); I_ch1_awlen = 8'd5;
    I_ch1_awsize = 3'd3; I_ch1_awburst = BURST_INCR;
    #3;
    checkOutput("abort_aw_ch1", 64'(O_ch1_awready), 64'd1);
    step();
    I_ch1_awvalid = 0; I_ch1_wvalid = 1; I_ch1_wdata = mkData(1'b1, 9, 0);
    step();
    step();
    #3;
    checkOutput("abort_wvalid_cnt2", 64'(O_axi_wvalid), 64'd1);
    checkOutput("abort_wlast_cnt2", 64'(O_axi_wlast), 64'd0);
    step();
    I_rst = 1;
    step();
    I_rst = 0;
    applyIdle(1'b1);
    #3;
    checkOutput("abort_outputs_zero", 64'(validReadyVec()), 64'd0);
    step();
    I_axi_bvalid = 0;
    I_ch0_awvalid = 1; I_ch0_awaddr = mkAddr(1'b0, 9); I_ch0_awlen = 8'd1; I_ch0_awburst = BURST_INCR;
    I_ch1_awvalid = 1; I_ch1_awaddr = mkAddr(1'b1, 9); I_ch1_awlen = 8'd1; I_ch1_awburst = BURST_INCR;
    #3;
    checkOutput("abort_prio_ch0_ready", 64'(O_ch0_awready), 64'd1);
    checkOutput("abort_prio_ch1_ready", 64'(O_ch1_awready), 64'd0);
    checkOutput("abort_prio_addr", 64'(O_axi_awaddr), 64'(mkAddr(1'b0, 9)));
    I_rst = 1;
    step();
    I_rst = 0;
    applyIdle(1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
